// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divide/remainder unit (DIV/DIVU/REM/REMU) that stalls EX while it iterates.
// Optional early-out for trivial cases is enabled by defining DIV_EARLY_OUT_EN.
module div_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              flush,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state, state_nxt;
    logic [1:0]          op_r;
    logic                sign_a, sign_b, dvsr_zero;
    logic [DATA_W-1:0]   rem_r, quo_r, dvsr_r;
    logic [CNT_W-1:0]    cnt_r;

    function automatic logic [DATA_W-1:0] neg_val(input logic [DATA_W-1:0] v);
        return {DATA_W{1'b0}} - v;
    endfunction

    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v,
                                                   input logic en);
        return (en && (v < 0)) ? neg_val(v) : v;
    endfunction

    logic                signed_in, accept, last_iter, sub_ok, signed_r;
    logic [DATA_W-1:0]   a_abs, b_abs, q_fix, r_fix;
    logic [DATA_W:0]     shifted, diff;
    logic                early_hit;
    logic [DATA_W-1:0]   early_result;

    assign signed_in = ~op[0];
    assign a_abs     = abs_val(dividend, signed_in);
    assign b_abs     = abs_val(divisor, signed_in);
    assign accept    = (state == IDLE) && start && !flush;
    assign last_iter = (cnt_r == CNT_W'(DATA_W - 1));

    // Iteration: the DATA_W+1-bit difference carries the borrow in its MSB
    assign shifted = {rem_r, quo_r[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvsr_r};
    assign sub_ok  = ~diff[DATA_W];

    // Sign fix-up: a zero divisor keeps the all-ones quotient untouched
    assign signed_r = ~op_r[0];
    assign q_fix    = (signed_r && (sign_a ^ sign_b) && !dvsr_zero) ? neg_val(quo_r) : quo_r;
    assign r_fix    = (signed_r && sign_a) ? neg_val(rem_r) : rem_r;

`ifdef DIV_EARLY_OUT_EN
    logic b_is_zero, ovf, small;
    assign b_is_zero = (divisor == '0);
    assign ovf       = signed_in && (dividend == {1'b1, {(DATA_W-1){1'b0}}}) && (divisor == '1);
    assign small     = (a_abs < b_abs);
    assign early_hit = b_is_zero || ovf || small;
    always_comb begin
        early_result = '0;
        if (b_is_zero)
            early_result = op[1] ? dividend : '1;
        else if (ovf)
            early_result = op[1] ? '0 : dividend;
        else if (small)
            early_result = op[1] ? dividend : '0;
    end
`else
    assign early_hit    = 1'b0;
    assign early_result = '0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = early_hit ? DONE : CALC;
            CALC: if (last_iter) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    assign stall = accept || (state == CALC) || (state == FIX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            op_r      <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            dvsr_zero <= 1'b0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvsr_r    <= '0;
            cnt_r     <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == CALC) || (state_nxt == FIX);
            done  <= (state_nxt == DONE);
            if (accept) begin
                op_r      <= op;
                sign_a    <= signed_in & dividend[DATA_W-1];
                sign_b    <= signed_in & divisor[DATA_W-1];
                dvsr_zero <= (divisor == '0);
                rem_r     <= '0;
                quo_r     <= a_abs;
                dvsr_r    <= b_abs;
                cnt_r     <= '0;
                if (early_hit) result <= early_result;
            end else if (!flush && state == CALC) begin
                rem_r <= sub_ok ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
                quo_r <= {quo_r[DATA_W-2:0], sub_ok};
                cnt_r <= cnt_r + CNT_W'(1);
            end else if (!flush && state == FIX) begin
                result <= op_r[1] ? r_fix : q_fix;
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: results, latency, stall/busy/done timing, flush and reset.
module tb_div_sequencer;
    localparam int W = 32;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, start, flush;
    logic [1:0]   op;
    logic [W-1:0] dividend, divisor, result;
    logic         stall, busy, done;

    int checks   = 0;
    int failures = 0;

    div_sequencer #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .flush(flush),
        .dividend(dividend), .divisor(divisor),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Called at a falling edge while the unit is IDLE; returns one cycle after done.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_r, input bit early);
        int   lat, cyc;
        logic stall_ok, busy1;
        lat = (early && EO) ? 1 : W + 2;
        op = o; dividend = a; divisor = b; start = 1'b1;
        #1;
        stall_ok = (stall === 1'b1);
        busy1 = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy1 = busy;
            if (done === 1'b1) break;
            if (stall !== 1'b1) stall_ok = 1'b0;
        end
        chk({tag, " latency"}, W'(cyc), W'(lat));
        chk({tag, " result"}, result, exp_r);
        chk1({tag, " stall_at_done"}, stall, 1'b0);
        chk1({tag, " stall_during"}, stall_ok, 1'b1);
        chk1({tag, " busy_cycle1"}, busy1, !(early && EO));
        start = 1'b0;
        @(negedge clk);
        chk1({tag, " done_after"}, done, 1'b0);
        chk1({tag, " busy_after"}, busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] prev;
        logic         saw_done;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk1("reset busy", busy, 1'b0);
        chk1("reset done", done, 1'b0);
        chk1("reset stall", stall, 1'b0);
        chk("reset result", result, '0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("div_100_7",    2'b00, 32'd100,        32'd7,          32'd14,         1'b0);
        do_op("rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0);
        do_op("remu_m7_2",    2'b11, 32'hFFFF_FFF9,  32'd2,          32'd1,          1'b0);
        do_op("div_m100_7",   2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0);
        do_op("rem_m100_7",   2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0);
        do_op("divu_5_0",     2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1);
        do_op("rem_5_0",      2'b10, 32'd5,          32'd0,          32'd5,          1'b1);
        do_op("div_m5_0",     2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1'b1);
        do_op("rem_m5_0",     2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1);
        do_op("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1);
        do_op("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1);
        do_op("div_3_10",     2'b00, 32'd3,          32'd10,         32'd0,          1'b1);
        do_op("rem_m3_10",    2'b10, 32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  1'b1);
        do_op("divu_big",     2'b01, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          1'b1);
        do_op("remu_big",     2'b11, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b1);
        do_op("divu_max_3",   2'b01, 32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  1'b0);

        // Flush mid-calculation: no done, result untouched, restart two cycles later
        prev = result;
        saw_done = 1'b0;
        op = 2'b00; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        flush = 1'b1;
        #1;
        chk1("flush stall_c10", stall, 1'b1);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        chk1("flush busy_c11", busy, 1'b0);
        chk1("flush done_c11", done, 1'b0);
        chk1("flush stall_c11", stall, 1'b0);
        chk("flush result_kept", result, prev);
        chk1("flush no_done", saw_done, 1'b0);
        @(negedge clk);
        do_op("flush_restart", 2'b00, 32'd100, 32'd7, 32'd14, 1'b0);

        // Asynchronous reset in the middle of CALC
        op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        repeat (5) @(negedge clk);
        chk1("pre_reset busy", busy, 1'b1);
        rst_n = 1'b0; start = 1'b0;
        #1;
        chk1("midrst busy", busy, 1'b0);
        chk1("midrst done", done, 1'b0);
        chk1("midrst stall", stall, 1'b0);
        chk("midrst result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("divu_max_16", 2'b01, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multi-cycle integer divide/remainder unit for the EX stage. It takes a DIV/DIVU/REM/REMU request from the pipeline and runs a radix-2 restoring division, one quotient bit per cycle. While it works it holds the pipeline stalled, then presents a RISC-V-compliant result with a one-cycle done pulse. It replaces a combinational divide path in the ALU, so the ALU's single-cycle critical path no longer includes division.

Parameters:
DATA_W, 32, operand/result width; iteration count equals DATA_W
CNT_W, $clog2(DATA_W)+1, iteration counter width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; held high by EX until done; sampled only in IDLE
op  in  2  func3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
flush  in  1  pipeline flush; aborts any in-flight operation
dividend  in  DATA_W  rs1 value, captured at accept
divisor  in  DATA_W  rs2 value, captured at accept
stall  out  1  hold IF/ID/EX; combinational
busy  out  1  registered; high in CALC and FIX
done  out  1  registered one-cycle pulse; result valid this cycle
result  out  DATA_W  quotient or remainder; held until next accept

Behaviour:
- Reset (rst_n low, async): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 and flush=0 -> accept. Latch op and the operand signs. For signed ops (op[0]=0), latch |dividend| and |divisor|; for unsigned ops, latch the raw values. Clear the remainder register and counter=0. Go to CALC.
- CALC: each cycle shift {rem,quo} left 1. Trial-subtract the divisor from rem; if the result is non-negative, keep it and set quo LSB=1. counter+1. After DATA_W iterations go to FIX.
- FIX: apply signs for signed ops. Quotient negated if sign(dividend)^sign(divisor). Remainder negated if sign(dividend). Select quo for op[1]=0 and rem for op[1]=1, write result. Go to DONE.
- DONE: done=1 for exactly this cycle. Return to IDLE next edge. start is ignored in DONE; no retrigger off the held start.
- Latency: start high in cycle 0 from IDLE -> done high in cycle DATA_W+2 (34 for DATA_W=32).
- stall = (state==IDLE & start & ~flush) | state==CALC | state==FIX. stall is low in DONE so the pipeline advances that cycle.
- Divide by zero: DIV/DIVU result=all ones; REM/REMU result=dividend. The natural restoring datapath yields this; FIX must not sign-adjust the quotient when divisor==0.
- Signed overflow (dividend=0x80000000, divisor=0xFFFFFFFF): DIV result=0x80000000, REM result=0. Sign correction must produce exactly this with DATA_W-bit wraparound.
- Width: all arithmetic modulo 2^DATA_W. The trial subtraction uses a DATA_W+1-bit difference; its MSB is the borrow.
- flush: synchronous, highest priority. In any state it forces IDLE on the next edge with done=0 and busy=0; result is unchanged. Flush together with start in IDLE means no accept.
- Back-to-back: a new start in the cycle after DONE (IDLE) is accepted normally.
- Reset mid-operation aborts immediately; no done pulse.

Optional Feature:
DIV_EARLY_OUT_EN. When defined, at accept in IDLE the unit detects divide-by-zero, signed overflow, or |dividend|<|divisor| (unsigned compare after abs). In those cases it writes the final result directly and goes IDLE->DONE, so done is in cycle 1. For |dividend|<|divisor|, the quotient is 0 and the remainder is the original dividend. When undefined, every operation takes the full DATA_W+2 latency; the results are bit-identical either way.

Test Plan:
DIV 100 / 7 (op=00), start cycle 0 -> done in cycle 34, result=14; stall high cycles 0-33, low cycle 34.
REM -7 / 2 (0xFFFFFFF9, 2, op=10) -> result=0xFFFFFFFF (-1); REMU same operands -> 1.
DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; with DIV_EARLY_OUT_EN, done in cycle 1.
DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0; no X, no extra done.
Start DIV 100/7, assert flush in cycle 10 -> state IDLE cycle 11, done never pulses, result keeps prior value. New start in cycle 12 -> done cycle 46.
Assert rst_n low mid-CALC -> busy, done, result are 0 asynchronously; after release, DIVU 0xFFFFFFFF / 16 -> 0x0FFFFFFF.
